// File: rtl/avalon_block_master.sv
// Avalon-MM block transfer master: runs block reads and block writes one word
// at a time, pulling write words from a stream source and pushing read words
// to a stream sink. Lengths above 16 words are clamped to 16.
module avalon_block_master #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // command
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  // write word source
  input  logic              wdata_valid_i,
  output logic              wdata_ready_o,
  input  logic [DATA_W-1:0] wdata_i,
  // read word sink
  output logic              rdata_valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [LEN_W-1:0]  rdata_idx_o,
  output logic              done_o,
  // Avalon-MM master
  output logic [ADDR_W-1:0] avm_addr_o,
  output logic              avm_read_o,
  output logic              avm_write_o,
  output logic [3:0]        avm_byte_en_o,
  output logic [DATA_W-1:0] avm_writedata_o,
  input  logic [DATA_W-1:0] avm_readdata_i,
  input  logic              avm_waitrequest_i
);

  localparam int unsigned MaxLen = 16;

  typedef enum logic [2:0] {StIdle, StRdReq, StWrWait, StWrReq, StFin} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [LEN_W-1:0]    rdata_idx_q, rdata_idx_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic [LEN_W-1:0]    len_clamped;

  assign len_clamped = (cmd_len_i > LEN_W'(MaxLen)) ? LEN_W'(MaxLen) : cmd_len_i;

  // Next-state, counter updates and state-decoded handshake/bus outputs.
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remain_d      = remain_q;
    idx_d         = idx_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rdata_idx_d   = rdata_idx_q;
    rdata_valid_d = 1'b0;
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    avm_read_o    = 1'b0;
    avm_write_o   = 1'b0;
    done_o        = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          cur_addr_d = cmd_addr_i;
          remain_d   = len_clamped;
          idx_d      = '0;
          if (len_clamped == '0) begin
            state_d = StFin;
          end else if (cmd_write_i) begin
            state_d = StWrWait;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StRdReq: begin
        avm_read_o = 1'b1;
        if (!avm_waitrequest_i) begin
          rdata_d       = avm_readdata_i;
          rdata_idx_d   = idx_q;
          rdata_valid_d = 1'b1;
          cur_addr_d    = cur_addr_q + 1'b1;
          idx_d         = idx_q + 1'b1;
          remain_d      = remain_q - 1'b1;
          // stay in StRdReq otherwise, keeping reads back-to-back
          if (remain_q == LEN_W'(1)) state_d = StFin;
        end
      end
      StWrWait: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i) begin
          wdata_d = wdata_i;
          state_d = StWrReq;
        end
      end
      StWrReq: begin
        avm_write_o = 1'b1;
        if (!avm_waitrequest_i) begin
          cur_addr_d = cur_addr_q + 1'b1;
          idx_d      = idx_q + 1'b1;
          remain_d   = remain_q - 1'b1;
          state_d    = (remain_q == LEN_W'(1)) ? StFin : StWrWait;
        end
      end
      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cur_addr_q    <= '0;
      remain_q      <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_idx_q   <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remain_q      <= remain_d;
      idx_q         <= idx_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      rdata_idx_q   <= rdata_idx_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign avm_addr_o      = cur_addr_q;
  assign avm_writedata_o = wdata_q;
  assign avm_byte_en_o   = 4'b1111;
  assign rdata_o         = rdata_q;
  assign rdata_idx_o     = rdata_idx_q;
  assign rdata_valid_o   = rdata_valid_q;

endmodule

// File: tb/tb_avalon_block_master.sv
// Directed bench for avalon_block_master. The slave returns addr*3 on reads;
// a negedge monitor logs every bus transfer, read strobe, DONE and command
// acceptance with the cycle number it happened in.
module tb_avalon_block_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [4:0]  cmd_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] wdata = '0;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic [4:0]  rdata_idx;
  logic        done;
  logic [7:0]  avm_addr;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byte_en;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        waitreq = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  avalon_block_master dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .cmd_write_i      (cmd_write),
    .cmd_addr_i       (cmd_addr),
    .cmd_len_i        (cmd_len),
    .wdata_valid_i    (wdata_valid),
    .wdata_ready_o    (wdata_ready),
    .wdata_i          (wdata),
    .rdata_valid_o    (rdata_valid),
    .rdata_o          (rdata),
    .rdata_idx_o      (rdata_idx),
    .done_o           (done),
    .avm_addr_o       (avm_addr),
    .avm_read_o       (avm_read),
    .avm_write_o      (avm_write),
    .avm_byte_en_o    (avm_byte_en),
    .avm_writedata_o  (avm_writedata),
    .avm_readdata_i   (avm_readdata),
    .avm_waitrequest_i(waitreq)
  );

  always #10 clk = ~clk;

  assign avm_readdata = {24'h0, avm_addr} * 32'd3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logs (indices only ever grow; tests remember a base index)
  int          rd_n = 0, ar_n = 0, aw_n = 0, done_n = 0, acc_n = 0;
  int          rd_cyc [256];
  logic [31:0] rd_data [256];
  logic [4:0]  rd_idx [256];
  logic [7:0]  ar_addr [256];
  int          aw_cyc [256];
  logic [7:0]  aw_addr [256];
  logic [31:0] aw_data [256];
  int          done_cyc [256];
  int          acc_cyc [256];
  int          ar_high = 0, aw_high = 0, both_n = 0;

  always @(negedge clk) begin
    if (rdata_valid && rd_n < 256) begin
      rd_cyc[rd_n] <= cyc; rd_data[rd_n] <= rdata; rd_idx[rd_n] <= rdata_idx;
      rd_n <= rd_n + 1;
    end
    if (avm_read) ar_high <= ar_high + 1;
    if (avm_write) aw_high <= aw_high + 1;
    if (avm_read && avm_write) both_n <= both_n + 1;
    if (avm_read && !waitreq && ar_n < 256) begin
      ar_addr[ar_n] <= avm_addr; ar_n <= ar_n + 1;
    end
    if (avm_write && !waitreq && aw_n < 256) begin
      aw_cyc[aw_n] <= cyc; aw_addr[aw_n] <= avm_addr; aw_data[aw_n] <= avm_writedata;
      aw_n <= aw_n + 1;
    end
    if (done && done_n < 256) begin
      done_cyc[done_n] <= cyc; done_n <= done_n + 1;
    end
    if (cmd_valid && cmd_ready && acc_n < 256) begin
      acc_cyc[acc_n] <= cyc; acc_n <= acc_n + 1;
    end
  end

  // Offers one command in cycle t0 (engine must be idle); returns in cycle t0+1.
  task automatic start_cmd(input logic wr, input logic [7:0] a, input logic [4:0] l,
                           output int t0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    t0 = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    for (int i = 0; i < budget && done_n == base; i++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (done_n == base) begin
      n_fail++;
      $display("FAIL %s_timeout: no DONE within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({cmd_ready, avm_read, avm_write, done, rdata_valid, wdata_ready} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 100000",
               {cmd_ready, avm_read, avm_write, done, rdata_valid, wdata_ready});
    end
    n_tests++;
    if (avm_addr !== 8'h00 || avm_writedata !== 32'h0 || rdata !== 32'h0 ||
        avm_byte_en !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_regs: addr %h wd %h rd %h be %h want 00 0 0 f",
               avm_addr, avm_writedata, rdata, avm_byte_en);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_basic();
    int t0, br, bd, bar;
    br = rd_n; bd = done_n; bar = ar_high;
    start_cmd(1'b0, 8'h17, 5'd4, t0);
    wait_done(bd, 20, "rd_basic");
    n_tests++;
    if (cmd_ready !== 1'b1 || cyc != t0 + 6) begin
      n_fail++;
      $display("FAIL rd_basic_ready: ready %b at cycle %0d want 1 at %0d", cmd_ready,
               cyc - t0, 6);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_data[br+i] !== 32'h45 + 32'(3 * i) || rd_idx[br+i] !== 5'(i) ||
          rd_cyc[br+i] != t0 + 2 + i) begin
        n_fail++;
        $display("FAIL rd_basic_word%0d: data %h idx %0d cyc %0d want %h %0d %0d", i,
                 rd_data[br+i], rd_idx[br+i], rd_cyc[br+i] - t0, 32'h45 + 32'(3 * i), i,
                 2 + i);
      end
    end
    n_tests++;
    if (done_cyc[bd] != t0 + 5 || ar_high - bar != 4 || rd_n - br != 4) begin
      n_fail++;
      $display("FAIL rd_basic_timing: done %0d rdhigh %0d words %0d want 5 4 4",
               done_cyc[bd] - t0, ar_high - bar, rd_n - br);
    end
  endtask

  task automatic test_write_stall();
    int t0, bw, bd, k, stalls, done_c;
    logic seen;
    bw = aw_n; bd = done_n; k = 0; stalls = 0; seen = 1'b0; done_c = 0;
    wdata_valid = 1'b1;
    start_cmd(1'b1, 8'h0D, 5'd3, t0);
    for (int c = 0; c < 40 && !seen; c++) begin
      if (wdata_ready && k < 3) begin
        wdata = 32'hA + 32'(k); k++;
      end
      waitreq = avm_write && avm_addr == 8'h0E && stalls < 2;
      if (waitreq) begin
        stalls++;
        n_tests++;
        if (avm_addr !== 8'h0E || avm_writedata !== 32'hB || avm_write !== 1'b1) begin
          n_fail++;
          $display("FAIL wr_stall_hold: addr %h data %h wr %b want 0e 0000000b 1",
                   avm_addr, avm_writedata, avm_write);
        end
      end
      if (done) begin
        seen = 1'b1; done_c = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    waitreq = 1'b0; wdata_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if (aw_n - bw != 3) begin
      n_fail++;
      $display("FAIL wr_stall_count: %0d writes want 3", aw_n - bw);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (aw_addr[bw+i] !== 8'h0D + 8'(i) || aw_data[bw+i] !== 32'hA + 32'(i)) begin
        n_fail++;
        $display("FAIL wr_stall_word%0d: addr %h data %h want %h %h", i, aw_addr[bw+i],
                 aw_data[bw+i], 8'h0D + 8'(i), 32'hA + 32'(i));
      end
    end
    n_tests++;
    if (!seen || done_c != t0 + 9 || done_c != aw_cyc[bw+2] + 1 || stalls != 2) begin
      n_fail++;
      $display("FAIL wr_stall_done: seen %b done %0d lastwr %0d stalls %0d want 1 9 8 2",
               seen, done_c - t0, aw_cyc[bw+2] - t0, stalls);
    end
  endtask

  task automatic test_wrap_clamp();
    int t0, br, bar, bd, bh;
    br = rd_n; bar = ar_n; bd = done_n;
    start_cmd(1'b0, 8'hFE, 5'd3, t0);
    wait_done(bd, 20, "wrap");
    n_tests++;
    if (ar_n - bar != 3 || ar_addr[bar] !== 8'hFE || ar_addr[bar+1] !== 8'hFF ||
        ar_addr[bar+2] !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_addr: n %0d addrs %h %h %h want 3 fe ff 00", ar_n - bar,
               ar_addr[bar], ar_addr[bar+1], ar_addr[bar+2]);
    end
    n_tests++;
    if (rd_data[br] !== 32'h2FA || rd_data[br+2] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_data: %h %h want 000002fa 00000000", rd_data[br], rd_data[br+2]);
    end
    br = rd_n; bar = ar_n; bd = done_n; bh = ar_high;
    start_cmd(1'b0, 8'h40, 5'd20, t0);
    wait_done(bd, 40, "clamp");
    n_tests++;
    if (ar_n - bar != 16 || ar_high - bh != 16 || rd_n - br != 16 ||
        rd_idx[br+15] !== 5'd15 || done_cyc[bd] != t0 + 17) begin
      n_fail++;
      $display("FAIL clamp: reads %0d high %0d words %0d lastidx %0d done %0d want 16 16 16 15 17",
               ar_n - bar, ar_high - bh, rd_n - br, rd_idx[br+15], done_cyc[bd] - t0);
    end
  endtask

  task automatic test_len_zero();
    int t0, bd, bh, bw;
    for (int w = 0; w < 2; w++) begin
      bd = done_n; bh = ar_high; bw = aw_high;
      start_cmd(w[0], 8'h20, 5'd0, t0);
      wait_done(bd, 10, "len0");
      n_tests++;
      if (done_cyc[bd] != t0 + 1 || ar_high != bh || aw_high != bw) begin
        n_fail++;
        $display("FAIL len0_wr%0d: done %0d rdhigh %0d wrhigh %0d want 1 0 0", w,
                 done_cyc[bd] - t0, ar_high - bh, aw_high - bw);
      end
    end
  endtask

  task automatic test_held_cmd();
    int t0, ba, bd, br;
    ba = acc_n; bd = done_n; br = rd_n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 5'd2;
    t0 = cyc;
    @(posedge clk); #1;
    cmd_addr = 8'h80; cmd_len = 5'd1;
    for (int i = 0; i < 20 && acc_n < ba + 2; i++) begin
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_done(bd + 1, 20, "held");
    @(posedge clk); #1;
    n_tests++;
    if (acc_n - ba != 2 || acc_cyc[ba+1] != t0 + 4 || done_cyc[bd] != t0 + 3) begin
      n_fail++;
      $display("FAIL held_accept: accepts %0d second %0d done %0d want 2 4 3", acc_n - ba,
               acc_cyc[ba+1] - t0, done_cyc[bd] - t0);
    end
    n_tests++;
    if (rd_n - br != 3 || rd_data[br+2] !== 32'h180 || rd_idx[br+2] !== 5'd0) begin
      n_fail++;
      $display("FAIL held_data: words %0d data %h idx %0d want 3 00000180 0", rd_n - br,
               rd_data[br+2], rd_idx[br+2]);
    end
  endtask

  task automatic test_starve();
    int t0, bw, bd, bh, k, done_c;
    logic seen;
    bw = aw_n; bd = done_n; bh = aw_high; k = 0; seen = 1'b0; done_c = 0;
    start_cmd(1'b1, 8'h30, 5'd2, t0);
    for (int c = 0; c < 40 && !seen; c++) begin
      if (cyc - t0 <= 5) begin
        wdata_valid = 1'b0;
        n_tests++;
        if (avm_write !== 1'b0 || wdata_ready !== 1'b1 || avm_addr !== 8'h30) begin
          n_fail++;
          $display("FAIL starve_idle: wr %b rdy %b addr %h want 0 1 30", avm_write,
                   wdata_ready, avm_addr);
        end
      end else begin
        wdata_valid = 1'b1;
        if (wdata_ready && k < 2) begin
          wdata = (k == 0) ? 32'h111 : 32'h222; k++;
        end
      end
      if (done) begin
        seen = 1'b1; done_c = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    wdata_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (aw_n - bw != 2 || aw_addr[bw] !== 8'h30 || aw_data[bw] !== 32'h111 ||
        aw_addr[bw+1] !== 8'h31 || aw_data[bw+1] !== 32'h222) begin
      n_fail++;
      $display("FAIL starve_writes: n %0d %h=%h %h=%h want 2 30=111 31=222", aw_n - bw,
               aw_addr[bw], aw_data[bw], aw_addr[bw+1], aw_data[bw+1]);
    end
    n_tests++;
    if (!seen || done_c != t0 + 10 || aw_high - bh != 2) begin
      n_fail++;
      $display("FAIL starve_done: seen %b done %0d wrhigh %0d want 1 10 2", seen,
               done_c - t0, aw_high - bh);
    end
  endtask

  task automatic test_reset_mid();
    int t0, bd, br;
    bd = done_n;
    start_cmd(1'b0, 8'h00, 5'd8, t0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if (avm_read !== 1'b1 || avm_addr !== 8'h02) begin
      n_fail++;
      $display("FAIL rstmid_pre: read %b addr %h want 1 02", avm_read, avm_addr);
    end
    #4 rst = 1'b1;
    #1;
    n_tests++;
    if (avm_read !== 1'b0 || cmd_ready !== 1'b1 || avm_addr !== 8'h00 ||
        rdata_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: read %b ready %b addr %h rv %b done %b want 0 1 00 0 0",
               avm_read, cmd_ready, avm_addr, rdata_valid, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (done_n != bd || cmd_ready !== 1'b1 || avm_read !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: dones %0d ready %b read %b want 0 1 0", done_n - bd,
               cmd_ready, avm_read);
    end
    br = rd_n; bd = done_n;
    start_cmd(1'b0, 8'h10, 5'd2, t0);
    wait_done(bd, 20, "rstmid_new");
    n_tests++;
    if (rd_n - br != 2 || rd_data[br] !== 32'h30 || rd_data[br+1] !== 32'h33 ||
        rd_idx[br] !== 5'd0 || rd_idx[br+1] !== 5'd1 || done_cyc[bd] != t0 + 3) begin
      n_fail++;
      $display("FAIL rstmid_new: n %0d %h/%0d %h/%0d done %0d want 2 30/0 33/1 3",
               rd_n - br, rd_data[br], rd_idx[br], rd_data[br+1], rd_idx[br+1],
               done_cyc[bd] - t0);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_stall();
    test_wrap_clamp();
    test_len_zero();
    test_held_cmd();
    test_starve();
    test_reset_mid();
    n_tests++;
    if (both_n != 0) begin
      n_fail++;
      $display("FAIL rd_wr_exclusive: %0d cycles with both strobes want 0", both_n);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/avalon_block_master.md
# avalon_block_master

Avalon-MM master engine that runs block read and block write transfers, one word at a time, against any 32-bit Avalon-MM slave register file, such as the body-data register file read by the display and physics FSM. A simple command handshake starts each transfer. Write words are pulled from a streaming source and read words are pushed to a streaming sink. The block sits between the physics/control logic and the Avalon fabric, so that logic can load or dump contiguous register ranges (for example, all 10 X positions) without processor involvement.

## Interface
- ADDR_W, 8, Avalon word-address width.
- DATA_W, 32, Avalon data width.
- LEN_W, 5, command length width; lengths 0..16 are legal, values 17..31 are clamped to 16.
- CLK  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  engine idle and able to accept a command.
- CMD_WRITE  in  1  1 = block write, 0 = block read.
- CMD_ADDR  in  ADDR_W  starting word address.
- CMD_LEN  in  LEN_W  number of words.
- WDATA_VALID  in  1  write word available.
- WDATA_READY  out  1  engine takes the write word this cycle.
- WDATA  in  DATA_W  write word.
- RDATA_VALID  out  1  one-cycle strobe; RDATA/RDATA_IDX are valid. There is no backpressure.
- RDATA  out  DATA_W  read word.
- RDATA_IDX  out  LEN_W  index of the word within the block, 0-based.
- DONE  out  1  one-cycle strobe at the end of each command.
- AVM_ADDR  out  ADDR_W  Avalon address.
- AVM_READ  out  1  Avalon read.
- AVM_WRITE  out  1  Avalon write.
- AVM_BYTE_EN  out  4  constant 4'b1111.
- AVM_WRITEDATA  out  DATA_W  Avalon write data.
- AVM_READDATA  in  DATA_W  Avalon read data; valid in the cycle AVM_READ=1 and AVM_WAITREQUEST=0.
- AVM_WAITREQUEST  in  1  slave stall.

## Operation
- **States:** IDLE, RD_REQ, WR_WAIT, WR_REQ, FIN.
- **Internal registers:** cur_addr (ADDR_W), remain (LEN_W), idx (LEN_W).
- **IDLE:**
  - CMD_READY=1.
  - On CMD_VALID: latch CMD_ADDR into cur_addr and the clamped length into remain, set idx=0.
  - Next state: len 0 → FIN with no bus access; read → RD_REQ; write → WR_WAIT.
- **RD_REQ:**
  - AVM_READ=1 and AVM_ADDR=cur_addr.
  - While AVM_WAITREQUEST=1, hold every Avalon output stable.
  - When AVM_WAITREQUEST=0:
    - Register AVM_READDATA into RDATA and idx into RDATA_IDX; pulse RDATA_VALID next cycle.
    - Update cur_addr+1, idx+1, remain−1.
    - If remain was 1 → FIN; otherwise stay in RD_REQ with AVM_READ continuously high (back-to-back reads).
- **WR_WAIT:**
  - WDATA_READY=1.
  - On WDATA_VALID: latch WDATA into AVM_WRITEDATA → WR_REQ.
- **WR_REQ:**
  - AVM_WRITE=1 and AVM_ADDR=cur_addr; hold while stalled.
  - On AVM_WAITREQUEST=0: advance counters; remain was 1 → FIN, else → WR_WAIT.
- **FIN:** DONE=1 for one cycle → IDLE.
- **Outputs:** AVM_READ and AVM_WRITE are decoded from state and are never both 1. WDATA_READY is 1 only in WR_WAIT. CMD_READY is 1 only in IDLE.
- **Address wrap:** cur_addr wraps modulo 2^ADDR_W (255 → 0). No error is raised.
- **CMD_VALID outside IDLE:** ignored. The command is not latched and must be held by the source.
- **WDATA_VALID outside WR_WAIT:** ignored.
- **RESET (any time, including mid-transfer):**
  - Asynchronously forces IDLE and clears cur_addr, remain, idx, RDATA, RDATA_IDX, AVM_WRITEDATA and AVM_ADDR to 0.
  - The in-flight transfer is abandoned, with no DONE pulse.
  - Output values under reset: AVM_READ=0, AVM_WRITE=0, RDATA_VALID=0, DONE=0, WDATA_READY=0, CMD_READY=1.

## Timing
- Command accepted at cycle 0 (CMD_VALID & CMD_READY).
- **Read of L words, no stalls:**
  - AVM_READ high cycles 1..L.
  - RDATA_VALID cycles 2..L+1.
  - DONE at cycle L+1.
  - CMD_READY again at cycle L+2.
- **Write of L words, data always valid, no stalls:**
  - WDATA_READY cycles 1, 3, …, 2L−1.
  - AVM_WRITE cycles 2, 4, …, 2L.
  - DONE at cycle 2L+1.
- Each cycle of AVM_WAITREQUEST=1 adds exactly one cycle of latency to that word.
- A length-0 command gives DONE at cycle 1.
- DONE and the last RDATA_VALID are asserted in the same cycle.

## Test plan
- **Read, no stalls:** read addr 0x17, len 4 from a slave model holding data=addr*3 → RDATA 0x45, 0x48, 0x4B, 0x4E with RDATA_IDX 0..3 on cycles 2..5; DONE on cycle 5; AVM_READ high exactly 4 cycles.
- **Write with stalls:** write addr 0x0D, len 3, WDATA 0xA, 0xB, 0xC, slave stalls 2 cycles on the second word → slave receives 0x0D=0xA, 0x0E=0xB, 0x0F=0xC; AVM_ADDR and AVM_WRITEDATA stable during the stall; DONE one cycle after the last accepted write.
- **Wrap and clamp:** read addr 0xFE, len 3 → accesses 0xFE, 0xFF, 0x00. Separately, CMD_LEN=20 → exactly 16 reads.
- **Length zero and held command:** len 0 → DONE at cycle 1 and no AVM_READ/AVM_WRITE. Separately, a second CMD_VALID held high during a busy transfer is accepted only after DONE, in the IDLE cycle.
- **Write-data starvation:** WDATA_VALID low for 5 cycles in WR_WAIT → AVM_WRITE stays 0 and no counter advances; the transfer resumes correctly.
- **Reset mid-transfer:** assert RESET during the third read of a len-8 transfer → AVM_READ drops asynchronously, no DONE; after release, CMD_READY=1 and a new len-2 read completes normally.
